// File: rtl/mips_fetch_queue.sv
// Instruction fetch front-end: sequential fetch address generation, credit-
// limited request issue to a variable-latency instruction memory, and a small
// prefetch FIFO of {inst, pc} pairs feeding decode. A redirect flushes the
// FIFO and discards every response still owed for pre-redirect requests.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. imem_req_valid is held until imem_req_ready, except in a
// redirect cycle, where it drops. dec_valid holds the head until dec_ready.
// imem_resp_valid has no ready: the credit rule reserves a FIFO slot for
// every outstanding request, so responses are always accepted.
module mips_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h00100000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [31:0]   r_inst [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;

  logic [CW:0]   w_credit_sum;
  logic          w_has_credit;
  logic          w_req_fire;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic [31:0]   w_redirect_aligned;
  logic [CW-1:0] w_out_after_resp;

  // Buffered words plus words still owed by memory must fit in the FIFO.
  assign w_credit_sum = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_has_credit = (w_credit_sum < (CW+1)'(DEPTH));

  assign imem_req_valid = ~reset & ~redirect_valid & w_has_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  // Stale responses are swallowed while drop_cnt is nonzero.
  assign w_drop = imem_resp_valid & (r_drop_cnt != '0);
  assign w_push = imem_resp_valid & (r_drop_cnt == '0);

  assign dec_valid = ~reset & (r_count != '0);
  assign dec_inst  = r_inst[r_rd_ptr];
  assign dec_pc    = r_pc[r_rd_ptr];
  assign w_pop     = dec_valid & dec_ready;

  assign w_redirect_aligned = redirect_pc & ~32'h3;
  assign w_out_after_resp   = r_outstanding - CW'(imem_resp_valid);

  // Control state: fetch/response PCs, FIFO pointers, credit and drop counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight (minus a response landing now, which is
      // itself discarded) belongs to the old stream and must be dropped.
      r_fetch_pc    <= w_redirect_aligned;
      r_resp_pc     <= w_redirect_aligned;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= w_out_after_resp;
      r_drop_cnt    <= w_out_after_resp;
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - 1'b1;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wr_ptr  <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage: write the returned word with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (!reset && !redirect_valid && w_push) begin
      r_inst[r_wr_ptr] <= imem_resp_data;
      r_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

  // Memory must never answer without a pending request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_resp_valid && (r_outstanding == '0)));
    end
  end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Testbench for mips_fetch_queue: table-driven per-cycle vectors for the
// streaming and back-pressure cases, then hand sequences for redirects,
// address wrap and mid-stream reset. A fixed-latency memory model answers
// accepted requests in order with a data word derived from the address.
module tb_mips_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  mips_fetch_queue #(.RESET_PC(32'h00100000), .DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_inst        (dec_inst),
    .dec_pc          (dec_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int lat    = 1;
  int cyc    = 0;

  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] pc_log[$];
  logic [31:0] inst_log[$];
  logic [31:0] exp_q[$];

  logic        s_acc;
  logic        s_rst;
  logic [31:0] s_addr;

  typedef struct {
    bit          restart;
    logic        dec_ready;
    logic        exp_req_valid;
    logic [31:0] exp_addr;
    logic        exp_dec_valid;
    logic [31:0] exp_dec_pc;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'h5A5AC3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Observe the cycle at the falling edge: what the coming rising edge will do.
  task automatic sample();
    @(negedge clk);
    s_rst  = reset;
    s_acc  = imem_req_valid & imem_req_ready;
    s_addr = imem_req_addr;
    if (s_acc) acc_log.push_back(imem_req_addr);
    if (dec_valid && dec_ready) begin
      pc_log.push_back(dec_pc);
      inst_log.push_back(dec_inst);
    end
    if (imem_resp_valid && mem_addr_q.size() > 0) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
  endtask

  // Cross the rising edge and update the memory model's response outputs.
  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    if (s_rst) begin
      mem_addr_q.delete();
      mem_due_q.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end else begin
      if (s_acc) begin
        mem_addr_q.push_back(s_addr);
        mem_due_q.push_back(cyc - 1 + lat);
      end
      if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memfn(mem_addr_q[0]);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end
    end
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic do_reset(input int ncyc);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    repeat (ncyc) step();
    reset = 1'b0;
    acc_log.delete();
    pc_log.delete();
    inst_log.delete();
  endtask

  // Decoded entries from index mark on must run start, start+4, ... with
  // matching instruction words, and there must be at least min_n of them.
  task automatic check_dec_seq(input string name, input int mark,
                               input logic [31:0] start, input int min_n);
    logic [31:0] e;
    chk({name, "_count_ok"}, 32'((pc_log.size() - mark) >= min_n), 32'd1);
    for (int j = mark; j < pc_log.size() && j < mark + 6; j++) begin
      e = start + 32'(4 * (j - mark));
      chk({name, "_pc"}, pc_log[j], e);
      chk({name, "_inst"}, inst_log[j], memfn(e));
    end
  endtask

  task automatic add_vec(input bit rs, input logic dr, input logic rv,
                         input logic [31:0] a, input logic dv, input logic [31:0] p);
    vec_t v;
    v.restart = rs; v.dec_ready = dr; v.exp_req_valid = rv;
    v.exp_addr = a; v.exp_dec_valid = dv; v.exp_dec_pc = p;
    vt.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  int mark;
  int amark;

  initial begin
    reset           = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    dec_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;

    // Streaming, 1-cycle latency, decode always ready: 2-cycle fill.
    for (int k = 0; k < 8; k++)
      add_vec(k == 0, 1'b1, 1'b1, 32'h00100000 + 32'(4 * k),
              k >= 2, (k >= 2) ? 32'h00100000 + 32'(4 * (k - 2)) : 32'h0);
    // Decode stalled: four requests fill the queue, one pop frees one credit.
    add_vec(1, 0, 1, 32'h00100000, 0, 32'h0);
    add_vec(0, 0, 1, 32'h00100004, 0, 32'h0);
    add_vec(0, 0, 1, 32'h00100008, 1, 32'h00100000);
    add_vec(0, 0, 1, 32'h0010000C, 1, 32'h00100000);
    add_vec(0, 0, 0, 32'h0,        1, 32'h00100000);
    add_vec(0, 1, 0, 32'h0,        1, 32'h00100000);
    add_vec(0, 0, 1, 32'h00100010, 1, 32'h00100004);
    add_vec(0, 0, 0, 32'h0,        1, 32'h00100004);
    add_vec(0, 0, 0, 32'h0,        1, 32'h00100004);

    lat = 1;
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].restart) begin
        dec_ready = vt[i].dec_ready;
        do_reset(2);
      end
      dec_ready = vt[i].dec_ready;
      sample();
      chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vt[i].exp_req_valid));
      if (vt[i].exp_req_valid)
        chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vt[i].exp_addr);
      chk($sformatf("vec%0d_dec_valid", i), 32'(dec_valid), 32'(vt[i].exp_dec_valid));
      if (vt[i].exp_dec_valid) begin
        chk($sformatf("vec%0d_dec_pc", i), dec_pc, vt[i].exp_dec_pc);
        chk($sformatf("vec%0d_dec_inst", i), dec_inst, memfn(vt[i].exp_dec_pc));
      end
      advance();
    end

    // Redirect with 3 outstanding at latency 3, one response landing that cycle.
    lat = 3; dec_ready = 1'b1;
    do_reset(2);
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h00100203;
    sample();
    chk("t3_resp_in_redirect", 32'(imem_resp_valid), 32'd1);
    chk("t3_req_valid_redirect", 32'(imem_req_valid), 32'd0);
    advance();
    redirect_valid = 1'b0;
    mark = pc_log.size();
    sample();
    chk("t3_dec_valid_after", 32'(dec_valid), 32'd0);
    chk("t3_req_valid_after", 32'(imem_req_valid), 32'd1);
    chk("t3_req_addr_after", imem_req_addr, 32'h00100200);
    advance();
    repeat (12) step();
    check_dec_seq("t3", mark, 32'h00100200, 3);

    // Back-to-back redirects: only the second stream may reach decode.
    lat = 2; dec_ready = 1'b1;
    do_reset(2);
    repeat (5) step();
    redirect_valid = 1'b1; redirect_pc = 32'h00100400;
    step();
    redirect_pc = 32'h00100800;
    sample();
    chk("t4_req_valid_redirect2", 32'(imem_req_valid), 32'd0);
    advance();
    redirect_valid = 1'b0;
    mark = pc_log.size();
    sample();
    chk("t4_dec_valid_after", 32'(dec_valid), 32'd0);
    chk("t4_req_valid_after", 32'(imem_req_valid), 32'd1);
    chk("t4_req_addr_after", imem_req_addr, 32'h00100800);
    advance();
    repeat (12) step();
    check_dec_seq("t4", mark, 32'h00100800, 3);

    // Address wrap at the top of the 32-bit space.
    lat = 1; dec_ready = 1'b1;
    do_reset(2);
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFF8;
    step();
    redirect_valid = 1'b0;
    amark = acc_log.size();
    mark  = pc_log.size();
    repeat (8) step();
    exp_q = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000};
    chk("t5_acc_count_ok", 32'((acc_log.size() - amark) >= 3), 32'd1);
    for (int j = 0; j < 3 && amark + j < acc_log.size(); j++)
      chk($sformatf("t5_acc_addr%0d", j), acc_log[amark + j], exp_q[j]);
    check_dec_seq("t5", mark, 32'hFFFFFFF8, 3);

    // Reset mid-stream with count=3 and one request outstanding.
    lat = 1; dec_ready = 1'b0;
    do_reset(2);
    repeat (3) step();
    sample();
    chk("t6_dec_valid_pre", 32'(dec_valid), 32'd1);
    chk("t6_req_valid_pre", 32'(imem_req_valid), 32'd1);
    advance();
    reset = 1'b1;
    step();
    sample();
    chk("t6_dec_valid_reset", 32'(dec_valid), 32'd0);
    chk("t6_req_valid_reset", 32'(imem_req_valid), 32'd0);
    advance();
    reset = 1'b0; imem_req_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (j == 2) imem_req_ready = 1'b1;
      sample();
      chk($sformatf("t6_hold_valid%0d", j), 32'(imem_req_valid), 32'd1);
      chk($sformatf("t6_hold_addr%0d", j), imem_req_addr, 32'h00100000);
      chk($sformatf("t6_hold_dec_valid%0d", j), 32'(dec_valid), 32'd0);
      advance();
    end
    sample();
    chk("t6_next_addr", imem_req_addr, 32'h00100004);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
